// File: rtl/fetch_sequencer.sv
// IF-stage fetch sequencer: owns the PC, keeps at most one instruction-memory read in flight,
// and buffers returned words in a small prefetch FIFO. Define FETCH_PERF_EN to add fetch/flush counters.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc4,
  input  logic        if_ready,
  input  logic        br_taken,
  input  logic [31:0] br_addr
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  localparam int unsigned    PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned    CW       = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]  DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0]  CNT_ZERO = {CW{1'b0}};
  localparam logic [PW-1:0]  LAST_PTR = PW'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [31:0]   r_pc;
  logic [31:0]   r_req_pc;
  logic          r_drop;
  logic          w_drop_nxt;
  logic          w_issue;
  logic          w_push;
  logic          w_pop;
  logic [31:0]   r_fifo_instr [DEPTH];
  logic [31:0]   r_fifo_pc4   [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? {PW{1'b0}} : p + PW'(1);
  endfunction

  // Next-state, issue and push decisions; a redirect suppresses issue and push this cycle
  always_comb begin
    w_state_nxt = r_state;
    w_drop_nxt  = r_drop;
    w_issue     = 1'b0;
    w_push      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!rst && !br_taken && (r_count < DEPTH_C)) begin
          w_issue     = 1'b1;
          w_state_nxt = ST_WAIT;
        end else begin
          w_issue     = 1'b0;
        end
      end
      ST_WAIT: begin
        if (imem_valid) begin
          w_state_nxt = ST_IDLE;
          w_drop_nxt  = 1'b0;
          w_push      = !r_drop && !br_taken;
        end else if (br_taken) begin
          w_drop_nxt  = 1'b1;
        end else begin
          w_drop_nxt  = r_drop;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_drop_nxt  = 1'b0;
      end
    endcase
  end

  assign w_pop     = (r_count != CNT_ZERO) && if_ready && !br_taken;
  assign imem_req  = w_issue;
  assign imem_addr = w_issue ? r_pc : 32'h0000_0000;
  assign if_valid  = (r_count != CNT_ZERO);
  assign if_instr  = if_valid ? r_fifo_instr[r_rd_ptr] : 32'h0000_0000;
  assign if_pc4    = if_valid ? r_fifo_pc4[r_rd_ptr]   : 32'h0000_0000;

  // Control state: FSM, PC, drop flag and FIFO pointers/occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_pc     <= RESET_PC;
      r_req_pc <= 32'h0000_0000;
      r_drop   <= 1'b0;
      r_rd_ptr <= {PW{1'b0}};
      r_wr_ptr <= {PW{1'b0}};
      r_count  <= CNT_ZERO;
    end else begin
      r_state <= w_state_nxt;
      r_drop  <= w_drop_nxt;
      if (br_taken) begin
        r_pc     <= br_addr & 32'hFFFF_FFFC;
        r_rd_ptr <= {PW{1'b0}};
        r_wr_ptr <= {PW{1'b0}};
        r_count  <= CNT_ZERO;
      end else begin
        if (w_issue) begin
          r_pc     <= r_pc + 32'd4;
          r_req_pc <= r_pc;
        end else begin
          r_pc     <= r_pc;
        end
        if (w_push) begin
          r_wr_ptr <= ptr_inc(r_wr_ptr);
        end else begin
          r_wr_ptr <= r_wr_ptr;
        end
        if (w_pop) begin
          r_rd_ptr <= ptr_inc(r_rd_ptr);
        end else begin
          r_rd_ptr <= r_rd_ptr;
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // FIFO payload storage; contents only matter while counted as occupied
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_fifo_instr[r_wr_ptr] <= imem_rdata;
      r_fifo_pc4[r_wr_ptr]   <= r_req_pc + 32'd4;
    end
  end

`ifdef FETCH_PERF_EN
  // Delivered-instruction and redirect counters, wrapping at 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= 32'h0000_0000;
      perf_flush_cnt <= 32'h0000_0000;
    end else begin
      if (w_pop) begin
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      end else begin
        perf_fetch_cnt <= perf_fetch_cnt;
      end
      if (br_taken) begin
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end else begin
        perf_flush_cnt <= perf_flush_cnt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: cycle table for reset/stall behaviour, a fetch scoreboard,
// and hand-written sequences for redirects, reset-in-flight and PC wrap (second instance).
module tb_fetch_sequencer;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc4;
  logic        if_ready;
  logic        br_taken;
  logic [31:0] br_addr;
  logic        wi_req;
  logic [31:0] wi_addr;
  logic        wi_valid;
  logic [31:0] wi_rdata;
  logic        wo_valid;
  logic [31:0] wo_instr;
  logic [31:0] wo_pc4;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_flush_cnt;
  logic [31:0] w_perf_fetch_cnt;
  logic [31:0] w_perf_flush_cnt;
`endif

  fetch_sequencer #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc4(if_pc4),
    .if_ready(if_ready), .br_taken(br_taken), .br_addr(br_addr)
`ifdef FETCH_PERF_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  fetch_sequencer #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_w (
    .clk(clk), .rst(rst),
    .imem_req(wi_req), .imem_addr(wi_addr),
    .imem_valid(wi_valid), .imem_rdata(wi_rdata),
    .if_valid(wo_valid), .if_instr(wo_instr), .if_pc4(wo_pc4),
    .if_ready(1'b1), .br_taken(1'b0), .br_addr(32'h0000_0000)
`ifdef FETCH_PERF_EN
    , .perf_fetch_cnt(w_perf_fetch_cnt), .perf_flush_cnt(w_perf_flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  typedef struct {
    logic        r;
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        v;
    logic [31:0] pc4;
  } vec_t;

  exp_t        sb_q[$];
  vec_t        vecs[$];
  int          n_tests;
  int          n_fail;
  int          mem_lat;
  logic [31:0] exp_pc;
  logic        m_pend, wm_pend;
  logic [31:0] m_addr, wm_addr;
  int          m_cnt, wm_cnt;
  logic        s_req, s_valid, sw_req, sw_valid;
  logic [31:0] s_addr, s_instr, s_pc4, sw_addr, sw_instr, sw_pc4;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return a ^ 32'hE1A0_5A5A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic r, input logic rdy, input logic req, input logic [31:0] addr,
                         input logic v, input logic [31:0] pc4);
    vec_t e;
    e.r = r; e.rdy = rdy; e.req = req; e.addr = addr; e.v = v; e.pc4 = pc4;
    vecs.push_back(e);
  endtask

  // One clock: drive inputs at the falling edge, sample, run the scoreboard, wait for next falling edge
  task automatic cycle(input logic r, input logic rdy, input logic br, input logic [31:0] ba);
    rst = r; if_ready = rdy; br_taken = br; br_addr = ba;
    if (m_pend && m_cnt == 0) begin
      imem_valid = 1'b1; imem_rdata = memfn(m_addr); m_pend = 1'b0;
    end else begin
      imem_valid = 1'b0; imem_rdata = 32'h0;
      if (m_pend) m_cnt--;
    end
    if (wm_pend && wm_cnt == 0) begin
      wi_valid = 1'b1; wi_rdata = memfn(wm_addr); wm_pend = 1'b0;
    end else begin
      wi_valid = 1'b0; wi_rdata = 32'h0;
      if (wm_pend) wm_cnt--;
    end
    #1;
    s_req = imem_req; s_addr = imem_addr; s_valid = if_valid; s_instr = if_instr; s_pc4 = if_pc4;
    sw_req = wi_req; sw_addr = wi_addr; sw_valid = wo_valid; sw_instr = wo_instr; sw_pc4 = wo_pc4;
    if (s_valid) begin
      if (sb_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL sb_unexpected_head: got pc4 %h expected no valid head", s_pc4);
      end else begin
        check("sb_instr", s_instr, sb_q[0].instr);
        check("sb_pc4", s_pc4, sb_q[0].pc4);
        if (rdy && !br && !r) void'(sb_q.pop_front());
      end
    end
    if (s_req) begin
      exp_t e;
      check("sb_addr", s_addr, exp_pc);
      e.instr = memfn(exp_pc); e.pc4 = exp_pc + 32'd4;
      sb_q.push_back(e);
      exp_pc = exp_pc + 32'd4;
      m_pend = 1'b1; m_addr = s_addr; m_cnt = mem_lat - 1;
    end
    if (sw_req) begin
      wm_pend = 1'b1; wm_addr = sw_addr; wm_cnt = mem_lat - 1;
    end
    if (r) begin
      sb_q.delete(); exp_pc = 32'h0;
    end else if (br) begin
      sb_q.delete(); exp_pc = ba & 32'hFFFF_FFFC;
    end
    @(negedge clk);
  endtask

  initial begin
    n_tests = 0; n_fail = 0; mem_lat = 1; exp_pc = 32'h0;
    m_pend = 1'b0; wm_pend = 1'b0; m_addr = 32'h0; wm_addr = 32'h0; m_cnt = 0; wm_cnt = 0;
    rst = 1'b1; if_ready = 1'b0; br_taken = 1'b0; br_addr = 32'h0;
    imem_valid = 1'b0; imem_rdata = 32'h0; wi_valid = 1'b0; wi_rdata = 32'h0;

    // reset-release fetch (ready=1), then a fresh reset and a 10-cycle hazard stall
    add_vec(1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0);
    add_vec(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    add_vec(1'b0, 1'b1, 1'b1, 32'h4, 1'b1, 32'h4);
    add_vec(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    add_vec(1'b0, 1'b1, 1'b1, 32'h8, 1'b1, 32'h8);
    add_vec(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    add_vec(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hC);
    add_vec(1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0);
    add_vec(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    add_vec(1'b0, 1'b0, 1'b1, 32'h4, 1'b1, 32'h4);
    for (int k = 0; k < 7; k++) add_vec(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h4);
    add_vec(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h4);
    add_vec(1'b0, 1'b1, 1'b1, 32'h8, 1'b1, 32'h8);
    add_vec(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    add_vec(1'b0, 1'b1, 1'b1, 32'hC, 1'b1, 32'hC);

    @(negedge clk);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    check("rst_req", 32'(s_req), 32'h0);
    check("rst_valid", 32'(s_valid), 32'h0);
    check("rst_instr", s_instr, 32'h0);
    check("rst_pc4", s_pc4, 32'h0);
`ifdef FETCH_PERF_EN
    check("rst_perf_fetch", perf_fetch_cnt, 32'h0);
    check("rst_perf_flush", perf_flush_cnt, 32'h0);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].r, vecs[i].rdy, 1'b0, 32'h0);
      check($sformatf("vec%0d_req", i), 32'(s_req), 32'(vecs[i].req));
      if (vecs[i].req) check($sformatf("vec%0d_addr", i), s_addr, vecs[i].addr);
      check($sformatf("vec%0d_valid", i), 32'(s_valid), 32'(vecs[i].v));
      check($sformatf("vec%0d_pc4", i), s_pc4, vecs[i].pc4);
      if (i == 0) check("wrap_addr0", sw_addr, 32'hFFFF_FFF8);
      if (i == 2) check("wrap_addr1", sw_addr, 32'hFFFF_FFFC);
      if (i == 4) begin
        check("wrap_req2", 32'(sw_req), 32'h1);
        check("wrap_addr2", sw_addr, 32'h0000_0000);
        check("wrap_valid", 32'(sw_valid), 32'h1);
        check("wrap_pc4", sw_pc4, 32'h0000_0000);
        check("wrap_instr", sw_instr, memfn(32'hFFFF_FFFC));
      end
    end

    // redirect while a slow read is outstanding: the late word must be dropped
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    mem_lat = 3;
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    check("br_wait_issue", 32'(s_req), 32'h1);
    cycle(1'b0, 1'b1, 1'b1, 32'h0000_0043);
    check("br_wait_req_on_br", 32'(s_req), 32'h0);
    mem_lat = 1;
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    check("br_wait_req_c2", 32'(s_req), 32'h0);
    check("br_wait_valid_c2", 32'(s_valid), 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    check("br_wait_req_c3", 32'(s_req), 32'h0);
    check("br_wait_valid_c3", 32'(s_valid), 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    check("br_target_req", 32'(s_req), 32'h1);
    check("br_target_addr", s_addr, 32'h0000_0040);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    check("br_target_valid_c5", 32'(s_valid), 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    check("br_target_valid", 32'(s_valid), 32'h1);
    check("br_target_pc4", s_pc4, 32'h0000_0044);

    // redirect coinciding with a response and a pop, then back-to-back redirects
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    check("brpop_pre_req", 32'(s_req), 32'h1);
    check("brpop_pre_addr", s_addr, 32'h4);
    cycle(1'b0, 1'b1, 1'b1, 32'h0000_0100);
    check("brpop_head_before", s_pc4, 32'h4);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    check("brpop_valid_after", 32'(s_valid), 32'h0);
    check("brpop_target_req", 32'(s_req), 32'h1);
    check("brpop_target_addr", s_addr, 32'h0000_0100);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    check("brpop_target_pc4", s_pc4, 32'h0000_0104);
    cycle(1'b0, 1'b1, 1'b1, 32'h0000_0200);
    cycle(1'b0, 1'b1, 1'b1, 32'h0000_0302);
    check("br2_req_on_br", 32'(s_req), 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    check("br2_last_wins_addr", s_addr, 32'h0000_0300);
    check("br2_last_wins_req", 32'(s_req), 32'h1);

    // reset while a read is in flight; the stray response after reset must be ignored
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    mem_lat = 2;
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    check("rstwait_req", 32'(s_req), 32'h1);
    check("rstwait_addr", s_addr, 32'h0);
    check("rstwait_valid_c2", 32'(s_valid), 32'h0);
`ifdef FETCH_PERF_EN
    check("rstwait_perf_fetch", perf_fetch_cnt, 32'h0);
    check("rstwait_perf_flush", perf_flush_cnt, 32'h0);
`endif
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    check("rstwait_valid_c3", 32'(s_valid), 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    check("rstwait_valid_c4", 32'(s_valid), 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    check("rstwait_valid_c5", 32'(s_valid), 32'h1);
    check("rstwait_pc4_c5", s_pc4, 32'h4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
